relu_seq_ctrl: RTL and testbench
================================

Name: relu_seq_ctrl

Overview:
- Sequencer that applies ReLU to a feature map held in a single-port buffer RAM, one element per cycle.
- Runs a 1-cycle-latency read, a per-element signed ReLU, and a write with a ready/valid handshake to the activation-map RAM.
- Sits between the conv-layer output buffer and the pooling stage. Replaces the flat all-elements-at-once ReLU once feature maps outgrow a single bus.

Parameters:
- FM_WIDTH, 5, feature-map columns
- FM_HEIGHT, 5, feature-map rows
- VALUE_SIZE, 16, element width, two's-complement signed
- ADDR_W, 5, RAM address width; must satisfy 2^ADDR_W >= FM_WIDTH*FM_HEIGHT
- LEAK_SHIFT, 3, right-shift for the negative slope (used only with RELU_LEAKY_EN)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle pulse; begins a pass when idle
- base_rd  in  ADDR_W  source base address, sampled on accepted start
- base_wr  in  ADDR_W  destination base address, sampled on accepted start
- busy  out  1  high from accepted start until done
- done  out  1  one-cycle pulse after the last element is written
- rd_en  out  1  source RAM read strobe
- rd_addr  out  ADDR_W  source address
- rd_data  in  VALUE_SIZE  source data, valid the cycle after rd_en
- wr_valid  out  1  output element valid
- wr_ready  in  1  sink accepts when wr_valid&&wr_ready
- wr_addr  out  ADDR_W  destination address
- wr_data  out  VALUE_SIZE  activated element

Behaviour:
- Reset values: busy=0, done=0, rd_en=0, rd_addr=0, wr_valid=0, wr_addr=0, wr_data=0, all counters 0, FSM=IDLE.
- N = FM_WIDTH*FM_HEIGHT elements per pass.
- FSM states:
  - IDLE: start=1 latches bases, clears counters, goes to RUN, busy=1 next cycle.
  - RUN: reads issue until rd_cnt==N, then go to DRAIN.
  - DRAIN: waits until wr_cnt==N, then goes to DONE.
  - DONE: done=1 for one cycle, busy=0, returns to IDLE.
- start while busy is ignored; no queuing.
- Read issue rule: rd_en=1 in a cycle only if state==RUN, rd_cnt<N, and (inflight + skid occupancy) < 2.
  - rd_addr = base_rd + rd_cnt, modulo 2^ADDR_W wrap-around.
- Element path: rd_data is captured the cycle after rd_en and ReLU is applied combinationally.
  - ReLU: MSB=1 gives 0, otherwise value passes.
  - 0x8000 gives 0x0000; 0x7FFF gives 0x7FFF; 0x0000 gives 0x0000.
- Result enters a 2-entry FIFO skid buffer; the head drives wr_valid/wr_data.
  - wr_addr = base_wr + wr_cnt, modulo 2^ADDR_W.
- Latency: rd_en at cycle t gives wr_valid at t+2 when the skid is empty.
  - Steady throughput is 1 element/cycle with wr_ready held high.
- Backpressure: wr_ready=0 holds wr_valid, wr_data and wr_addr stable, with no drop and no duplication.
  - Reads stall by the occupancy rule; in-flight data always has a skid slot.
- Simultaneous push and pop on a full skid is legal; occupancy is unchanged.
- wr_cnt increments only on a handshake. done fires the cycle after the handshake of element N-1.
- Reset mid-pass: immediate return to reset values; partial writes are abandoned and no done is issued.

Optional Feature:
- Macro RELU_LEAKY_EN.
- When defined: negative inputs produce an arithmetic shift right by LEAK_SHIFT (sign-extended), e.g. 0xFFF0 (-16) with LEAK_SHIFT=3 gives 0xFFFE (-2).
- When undefined: plain ReLU, negatives give 0, and LEAK_SHIFT is unused.

Decomposition:
- Shared package relu_pkg: FSM state typedef (IDLE, RUN, DRAIN, DONE), default VALUE_SIZE, and an element function relu_elem (leaky variant under the macro).
- Sub-module relu_skid_fifo: 2-entry, parameterised by data width (VALUE_SIZE+ADDR_W). Ports push/pop/full/empty/count.

Test Plan:
- Basic pass:
  - Stimulus: source RAM with alternating 0xFFFF/0x0FFF, base_rd=0, base_wr=0, wr_ready=1, start pulse.
  - Required: 25 writes, even addresses 0x0000, odd 0x0FFF; first wr_valid 3 cycles after start; done on the cycle after the 25th handshake.
- Backpressure:
  - Stimulus: wr_ready toggles 1-0-0-1 randomly.
  - Required: the written sequence equals the expected ReLU of all 25 elements in order, with no gaps or duplicates; wr_data is stable while wr_valid&&!wr_ready.
- Boundary values:
  - Stimulus: elements 0x8000, 0x7FFF, 0x0000, 0xFFFF.
  - Required outputs: 0x0000, 0x7FFF, 0x0000, 0x0000. With RELU_LEAKY_EN and LEAK_SHIFT=3, 0xFFFF gives 0xFFFF and 0x8000 gives 0xF000.
- Address wrap:
  - Stimulus: base_rd=30, base_wr=28, ADDR_W=5.
  - Required: rd_addr sequence 30, 31, 0, 1, ... and wr_addr 28..31, 0, ...
- Start while busy:
  - Stimulus: second start 5 cycles into a pass.
  - Required: ignored; exactly 25 writes and one done.
- Reset mid-pass:
  - Stimulus: rst_n low at element 10.
  - Required: all outputs 0 immediately, no done; a new start afterwards completes a full 25-element pass.

Source files
------------

// File: rtl/relu_pkg.sv
// Shared types and the per-element activation for the ReLU sequencer.
// Define RELU_LEAKY_EN to turn negative inputs into an arithmetic right shift.
package relu_pkg;

    localparam int unsigned VALUE_SIZE_DEF = 16;

    typedef logic [1:0] state_t;

    localparam state_t StIdle  = 2'd0;
    localparam state_t StRun   = 2'd1;
    localparam state_t StDrain = 2'd2;
    localparam state_t StDone  = 2'd3;

`ifdef RELU_LEAKY_EN
    localparam bit LeakyEn = 1'b1;
`else
    localparam bit LeakyEn = 1'b0;
`endif

    // Operates on a sign-extended 64-bit value so any element width up to 64 can reuse it.
    function automatic logic signed [63:0] relu_elem(input logic signed [63:0] x,
                                                     input int unsigned shift);
        if (x[63]) begin
            return LeakyEn ? (x >>> shift) : '0;
        end
        return x;
    endfunction

endpackage

// File: rtl/relu_skid_fifo.sv
// Two-entry FIFO used as the skid buffer between the read path and the write handshake.
// Push and pop in the same cycle is accepted even when full.
module relu_skid_fifo #(
    parameter int unsigned WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty,
    output logic [1:0]       count
);

    logic [WIDTH-1:0] mem_q [2];
    logic [WIDTH-1:0] mem_d [2];
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic [1:0]       count_q, count_d;
    logic             do_push, do_pop;

    always_comb begin
        do_pop   = pop && (count_q != 2'd0);
        do_push  = push && ((count_q != 2'd2) || do_pop);
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        if (do_push && !do_pop) begin
            count_d = count_q + 2'd1;
        end else if (!do_push && do_pop) begin
            count_d = count_q - 2'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_q    <= '{default: '0};
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    assign pop_data = mem_q[rd_ptr_q];
    assign full     = (count_q == 2'd2);
    assign empty    = (count_q == 2'd0);
    assign count    = count_q;

endmodule

// File: rtl/relu_seq_ctrl.sv
// Streams a feature map from the source RAM through ReLU into the activation-map RAM.
// Optional macro RELU_LEAKY_EN selects the leaky slope (shift by LEAK_SHIFT) for negatives.
module relu_seq_ctrl
    import relu_pkg::*;
#(
    parameter int unsigned FM_WIDTH   = 5,
    parameter int unsigned FM_HEIGHT  = 5,
    parameter int unsigned VALUE_SIZE = VALUE_SIZE_DEF,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned LEAK_SHIFT = 3
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [ADDR_W-1:0]     base_rd,
    input  logic [ADDR_W-1:0]     base_wr,
    output logic                  busy,
    output logic                  done,
    output logic                  rd_en,
    output logic [ADDR_W-1:0]     rd_addr,
    input  logic [VALUE_SIZE-1:0] rd_data,
    output logic                  wr_valid,
    input  logic                  wr_ready,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [VALUE_SIZE-1:0] wr_data
);

    localparam int unsigned N     = FM_WIDTH * FM_HEIGHT;
    localparam int unsigned CNT_W = ADDR_W + 1;
    localparam int unsigned ENT_W = VALUE_SIZE + ADDR_W;
    localparam logic [CNT_W-1:0] NumElems = CNT_W'(N);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] base_rd_q, base_rd_d;
    logic [ADDR_W-1:0] base_wr_q, base_wr_d;
    logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
    logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
    logic              inflight_q, inflight_d;
    logic [ADDR_W-1:0] inflight_idx_q, inflight_idx_d;

    logic              pop;
    logic [2:0]        occ;
    logic [VALUE_SIZE-1:0] relu_val;
    logic [ENT_W-1:0]  push_data, head;
    logic              fifo_full, fifo_empty;
    logic [1:0]        fifo_count;

    assign relu_val  = VALUE_SIZE'(relu_elem(64'(signed'(rd_data)), LEAK_SHIFT));
    assign push_data = {base_wr_q + inflight_idx_q, relu_val};

    relu_skid_fifo #(
        .WIDTH(ENT_W)
    ) u_skid (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (inflight_q),
        .push_data(push_data),
        .pop      (pop),
        .pop_data (head),
        .full     (fifo_full),
        .empty    (fifo_empty),
        .count    (fifo_count)
    );

    always_comb begin
        wr_valid = !fifo_empty;
        pop      = wr_valid && wr_ready;
        wr_data  = wr_valid ? head[VALUE_SIZE-1:0] : '0;
        wr_addr  = wr_valid ? head[ENT_W-1:VALUE_SIZE] : '0;
        // Counting the current pop keeps 1 element/cycle while guaranteeing a slot for in-flight data.
        occ      = 3'(inflight_q) + 3'(fifo_count) - 3'(pop);
        rd_en    = (state_q == StRun) && (rd_cnt_q < NumElems) && (occ < 3'd2) && !fifo_full;
        rd_addr  = base_rd_q + rd_cnt_q[ADDR_W-1:0];
        busy     = (state_q == StRun) || (state_q == StDrain);
        done     = (state_q == StDone);
    end

    always_comb begin
        state_d        = state_q;
        base_rd_d      = base_rd_q;
        base_wr_d      = base_wr_q;
        rd_cnt_d       = rd_cnt_q + CNT_W'(rd_en);
        wr_cnt_d       = wr_cnt_q + CNT_W'(pop);
        inflight_d     = rd_en;
        inflight_idx_d = rd_cnt_q[ADDR_W-1:0];
        unique case (state_q)
            StIdle: begin
                if (start) begin
                    base_rd_d = base_rd;
                    base_wr_d = base_wr;
                    rd_cnt_d  = '0;
                    wr_cnt_d  = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                if (rd_cnt_q == NumElems) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (wr_cnt_d == NumElems) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= StIdle;
            base_rd_q      <= '0;
            base_wr_q      <= '0;
            rd_cnt_q       <= '0;
            wr_cnt_q       <= '0;
            inflight_q     <= 1'b0;
            inflight_idx_q <= '0;
        end else begin
            state_q        <= state_d;
            base_rd_q      <= base_rd_d;
            base_wr_q      <= base_wr_d;
            rd_cnt_q       <= rd_cnt_d;
            wr_cnt_q       <= wr_cnt_d;
            inflight_q     <= inflight_d;
            inflight_idx_q <= inflight_idx_d;
        end
    end

endmodule

// File: tb/tb_relu_seq_ctrl.sv
// Randomised scoreboard bench for relu_seq_ctrl; expectations come from a queue-based model.
module tb_relu_seq_ctrl;

    localparam int FW = 5, FH = 5, VS = 16, AW = 5, LS = 3;
    localparam int N = FW * FH;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_rd = '0, base_wr = '0;
    logic          busy, done, rd_en, wr_valid;
    logic [AW-1:0] rd_addr, wr_addr;
    logic [VS-1:0] rd_data, wr_data;
    logic          wr_ready = 1'b1;

    always #5 clk = ~clk;

    relu_seq_ctrl #(
        .FM_WIDTH  (FW),
        .FM_HEIGHT (FH),
        .VALUE_SIZE(VS),
        .ADDR_W    (AW),
        .LEAK_SHIFT(LS)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .base_rd (base_rd),
        .base_wr (base_wr),
        .busy    (busy),
        .done    (done),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_addr (wr_addr),
        .wr_data (wr_data)
    );

    // Source RAM with one-cycle read latency.
    logic [VS-1:0] src_mem [DEPTH];
    always @(posedge clk) if (rd_en) rd_data <= src_mem[rd_addr];

    int checks = 0, errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [AW+VS-1:0] exp_wr_q[$];
    logic [AW-1:0]    exp_rd_q[$];
    bit               bp_mode = 0;
    int               hs_cnt = 0, done_cnt = 0, last_hs_cyc = -10, first_valid_cyc = -1;
    bit               stall_prev = 0;
    logic [AW+VS-1:0] stall_val;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_event(input string name, input logic [31:0] act);
        checks++;
        errors++;
        $display("FAIL %s: got 0x%0h, required no such event (t=%0t)", name, act, $time);
    endtask

    function automatic logic [VS-1:0] relu_model(input logic [VS-1:0] x);
        int v;
        v = $signed(x);
`ifdef RELU_LEAKY_EN
        if (v < 0) v = v >>> LS;
`else
        if (v < 0) v = 0;
`endif
        return VS'(v);
    endfunction

    // Monitor: compares DUT activity against the scoreboard queues.
    always @(negedge clk) begin
        if (rst_n) begin
            if (rd_en) begin
                if (exp_rd_q.size() == 0) fail_event("rd_extra", 32'(rd_addr));
                else chk("rd_addr", 32'(rd_addr), 32'(exp_rd_q.pop_front()));
            end
            if (stall_prev) begin
                chk("wr_hold_valid", 32'(wr_valid), 32'd1);
                chk("wr_hold_value", 32'({wr_addr, wr_data}), 32'(stall_val));
            end
            if (wr_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (wr_valid && wr_ready) begin
                if (exp_wr_q.size() == 0) fail_event("wr_extra", 32'({wr_addr, wr_data}));
                else chk("wr_elem", 32'({wr_addr, wr_data}), 32'(exp_wr_q.pop_front()));
                hs_cnt++;
                last_hs_cyc = cyc;
            end
            stall_prev = wr_valid && !wr_ready;
            stall_val  = {wr_addr, wr_data};
            if (done) begin
                done_cnt++;
                chk("done_timing", 32'(cyc), 32'(last_hs_cyc + 1));
            end
        end else begin
            stall_prev = 0;
        end
    end

    initial forever begin
        @(posedge clk);
        #1;
        wr_ready = bp_mode ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_busy"},     32'(busy),     32'd0);
        chk({tag, "_done"},     32'(done),     32'd0);
        chk({tag, "_rd_en"},    32'(rd_en),    32'd0);
        chk({tag, "_rd_addr"},  32'(rd_addr),  32'd0);
        chk({tag, "_wr_valid"}, 32'(wr_valid), 32'd0);
        chk({tag, "_wr_addr"},  32'(wr_addr),  32'd0);
        chk({tag, "_wr_data"},  32'(wr_data),  32'd0);
    endtask

    task automatic run_pass(input logic [AW-1:0] brd, input logic [AW-1:0] bwr,
                            input int again_at, input int rst_at, input bit chk_lat);
        int start_cyc;
        bit got_done;
        for (int i = 0; i < N; i++) begin
            exp_rd_q.push_back(AW'(brd + i));
            exp_wr_q.push_back({AW'(bwr + i), relu_model(src_mem[AW'(brd + i)])});
        end
        hs_cnt = 0; done_cnt = 0; first_valid_cyc = -1; last_hs_cyc = -10;
        @(negedge clk);
        base_rd = brd; base_wr = bwr; start = 1'b1; start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        got_done = 0;
        for (int c = 0; c < 1000 && !got_done; c++) begin
            if (c == again_at) begin
                start = 1'b1; base_rd = ~brd; base_wr = ~bwr;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            if (rst_at >= 0 && hs_cnt >= rst_at) begin
                start = 1'b0;
                rst_n = 1'b0;
                #1;
                check_reset_outputs("midrst");
                exp_rd_q.delete();
                exp_wr_q.delete();
                repeat (3) @(negedge clk);
                rst_n = 1'b1;
                repeat (4) @(negedge clk);
                chk("no_done_after_rst", 32'(done_cnt), 32'd0);
                return;
            end
            if (done_cnt > 0) got_done = 1;
        end
        start = 1'b0;
        if (!got_done) fail_event("done_timeout", 32'(hs_cnt));
        repeat (4) @(negedge clk);
        chk("pass_writes", 32'(hs_cnt), 32'(N));
        chk("pass_dones", 32'(done_cnt), 32'd1);
        chk("pass_wr_left", 32'(exp_wr_q.size()), 32'd0);
        chk("pass_rd_left", 32'(exp_rd_q.size()), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        if (chk_lat) chk("first_valid_latency", 32'(first_valid_cyc - start_cyc), 32'd3);
        exp_rd_q.delete();
        exp_wr_q.delete();
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) src_mem[i] = VS'($urandom);
        #1;
        check_reset_outputs("reset");
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Basic pass: alternating negative/positive.
        for (int i = 0; i < DEPTH; i++) src_mem[i] = (i % 2 == 0) ? 16'hFFFF : 16'h0FFF;
        run_pass(5'd0, 5'd0, -1, -1, 1);

        // Random backpressure.
        for (int i = 0; i < DEPTH; i++) src_mem[i] = VS'($urandom);
        bp_mode = 1;
        run_pass(AW'($urandom), AW'($urandom), -1, -1, 0);

        // Boundary values.
        bp_mode = 0;
        src_mem[4] = 16'h8000; src_mem[5] = 16'h7FFF;
        src_mem[6] = 16'h0000; src_mem[7] = 16'hFFFF;
        run_pass(5'd4, 5'd10, -1, -1, 0);

        // Address wrap under backpressure.
        bp_mode = 1;
        run_pass(5'd30, 5'd28, -1, -1, 0);

        // Start while busy is ignored.
        run_pass(5'd3, 5'd7, 4, -1, 0);

        // Reset mid-pass, then a full pass.
        bp_mode = 0;
        run_pass(5'd0, 5'd0, -1, 10, 0);
        run_pass(5'd0, 5'd0, -1, -1, 1);

        bp_mode = 1;
        for (int k = 0; k < 3; k++) begin
            for (int i = 0; i < DEPTH; i++) src_mem[i] = VS'($urandom);
            run_pass(AW'($urandom), AW'($urandom), -1, -1, 0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
